hazard_ctrl: RTL and testbench

//   Pipeline hazard/forwarding controller for the 5-stage MIPS core. Tracks in-flight

---
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core: tracks E/M/W/WW destinations with Tnew,
// drives D- and E-stage operand selects and the stall. Optional counters under HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic              D_rs_used,
  input  logic              D_rt_used,
  input  logic [TNEW_W-1:0] D_rs_tuse,
  input  logic [TNEW_W-1:0] D_rt_tuse,
  input  logic [REG_AW-1:0] D_dst,
  input  logic [TNEW_W-1:0] D_tnew,
  input  logic              flush,
  output logic              stall,
  output logic [2:0]        s_D_rs_data,
  output logic [2:0]        s_D_rt_data,
  output logic [2:0]        s_E_rs_data,
  output logic [2:0]        s_E_rt_data
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam logic [2:0] SEL_O  = 3'b000;
  localparam logic [2:0] SEL_E  = 3'b001;
  localparam logic [2:0] SEL_M  = 3'b010;
  localparam logic [2:0] SEL_W  = 3'b011;
  localparam logic [2:0] SEL_WW = 3'b100;

  // Tracked stages: p0 = E, p1 = M, p2 = W, p3 = WW
  logic              vld_p0, vld_p1, vld_p2, vld_p3;
  logic [REG_AW-1:0] dst_p0, dst_p1, dst_p2, dst_p3;
  logic [TNEW_W-1:0] tnew_p0, tnew_p1, tnew_p2, tnew_p3;
  logic [REG_AW-1:0] rs_p0, rt_p0;
  logic              rs_stall, rt_stall;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // Returns {stall_request, select} for one D-stage operand.
  function automatic logic [3:0] d_lookup(input logic [REG_AW-1:0] r, input logic used,
                                          input logic [TNEW_W-1:0] tuse);
    logic              hit;
    logic [TNEW_W-1:0] t;
    logic [2:0]        code;
    hit  = 1'b0;
    t    = '0;
    code = SEL_O;
    if (used && r != '0) begin
      if (vld_p0 && dst_p0 == r) begin
        hit = 1'b1; t = tnew_p0; code = SEL_E;
      end else if (vld_p1 && dst_p1 == r) begin
        hit = 1'b1; t = tnew_p1; code = SEL_M;
      end else if (vld_p2 && dst_p2 == r) begin
        hit = 1'b1; t = tnew_p2; code = SEL_W;
      end else if (vld_p3 && dst_p3 == r) begin
        hit = 1'b1; t = tnew_p3; code = SEL_WW;
      end
    end
    if (!hit)            return {1'b0, SEL_O};
    else if (t == '0)    return {1'b0, code};
    else if (t <= tuse)  return {1'b0, SEL_O};
    else                 return {1'b1, SEL_O};
  endfunction

  // A younger producer still computing hides older copies of the same register.
  function automatic logic [2:0] e_lookup(input logic [REG_AW-1:0] r);
    if (r == '0)                      return SEL_O;
    else if (vld_p1 && dst_p1 == r)   return (tnew_p1 == '0) ? SEL_M  : SEL_O;
    else if (vld_p2 && dst_p2 == r)   return (tnew_p2 == '0) ? SEL_W  : SEL_O;
    else if (vld_p3 && dst_p3 == r)   return (tnew_p3 == '0) ? SEL_WW : SEL_O;
    else                              return SEL_O;
  endfunction

  always_comb begin
    {rs_stall, s_D_rs_data} = d_lookup(D_rs, D_rs_used, D_rs_tuse);
    {rt_stall, s_D_rt_data} = d_lookup(D_rt, D_rt_used, D_rt_tuse);
    stall       = rs_stall | rt_stall;
    s_E_rs_data = e_lookup(rs_p0);
    s_E_rt_data = e_lookup(rt_p0);
  end

  // D -> E entry, then E -> M -> W -> WW with Tnew counting down
  always_ff @(posedge clk) begin
    if (rst) begin
      {vld_p0, vld_p1, vld_p2, vld_p3} <= '0;
      {dst_p0, dst_p1, dst_p2, dst_p3} <= '0;
      {tnew_p0, tnew_p1, tnew_p2, tnew_p3} <= '0;
      rs_p0 <= '0;
      rt_p0 <= '0;
    end else begin
      vld_p3  <= vld_p2;
      dst_p3  <= dst_p2;
      tnew_p3 <= tnew_dec(tnew_p2);
      vld_p2  <= vld_p1;
      dst_p2  <= dst_p1;
      tnew_p2 <= tnew_dec(tnew_p1);
      vld_p1  <= vld_p0;
      dst_p1  <= dst_p0;
      tnew_p1 <= tnew_dec(tnew_p0);
      if (!stall && !flush) begin
        vld_p0  <= (D_dst != '0);
        dst_p0  <= D_dst;
        tnew_p0 <= D_tnew;
        rs_p0   <= D_rs;
        rt_p0   <= D_rt;
      end else begin
        vld_p0  <= 1'b0;
        dst_p0  <= '0;
        tnew_p0 <= '0;
        rs_p0   <= '0;
        rt_p0   <= '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (s_D_rs_data != SEL_O || s_D_rt_data != SEL_O) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: array-based pipeline model, per-cycle compare, directed pins plus random traffic.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] D_rs, D_rt, D_dst;
  logic       D_rs_used, D_rt_used, flush;
  logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew;
  logic       stall;
  logic [2:0] s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .TNEW_W(2)) dut (
    .clk(clk), .rst(rst), .D_rs(D_rs), .D_rt(D_rt), .D_rs_used(D_rs_used), .D_rt_used(D_rt_used),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_dst(D_dst), .D_tnew(D_tnew), .flush(flush),
    .stall(stall), .s_D_rs_data(s_D_rs_data), .s_D_rt_data(s_D_rt_data),
    .s_E_rs_data(s_E_rs_data), .s_E_rt_data(s_E_rt_data)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Model: index 0..3 = E, M, W, WW; forwarding code of stage k is k+1
  logic       mv[4];
  logic [4:0] md[4];
  logic [1:0] mt[4];
  logic [4:0] ers, ert;

  function automatic logic [3:0] exp_d(input logic [4:0] r, input logic used, input logic [1:0] tuse);
    if (!used || r == 5'd0) return 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (mv[k] && md[k] == r) begin
        if (mt[k] == 2'd0) return {1'b0, 3'(k + 1)};
        if (mt[k] <= tuse) return 4'd0;
        return 4'b1000;
      end
    end
    return 4'd0;
  endfunction

  function automatic logic [2:0] exp_e(input logic [4:0] r);
    if (r == 5'd0) return 3'd0;
    for (int k = 1; k < 4; k++) begin
      if (mv[k] && md[k] == r) return (mt[k] == 2'd0) ? 3'(k + 1) : 3'd0;
    end
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] a, b;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mv[k] = 1'b0; md[k] = 5'd0; mt[k] = 2'd0;
      end
      ers = 5'd0; ert = 5'd0;
      started = 1'b1;
    end else if (started) begin
      a = exp_d(D_rs, D_rs_used, D_rs_tuse);
      b = exp_d(D_rt, D_rt_used, D_rt_tuse);
      for (int k = 3; k > 0; k--) begin
        mv[k] = mv[k-1];
        md[k] = md[k-1];
        mt[k] = (mt[k-1] == 2'd0) ? 2'd0 : mt[k-1] - 2'd1;
      end
      if (!(a[3] | b[3]) && !flush) begin
        mv[0] = (D_dst != 5'd0); md[0] = D_dst; mt[0] = D_tnew; ers = D_rs; ert = D_rt;
      end else begin
        mv[0] = 1'b0; md[0] = 5'd0; mt[0] = 2'd0; ers = 5'd0; ert = 5'd0;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] a, b;
    if (started) begin
      a = exp_d(D_rs, D_rs_used, D_rs_tuse);
      b = exp_d(D_rt, D_rt_used, D_rt_tuse);
      check("stall", 32'(stall), 32'(a[3] | b[3]));
      check("s_D_rs", 32'(s_D_rs_data), 32'(a[2:0]));
      check("s_D_rt", 32'(s_D_rt_data), 32'(b[2:0]));
      check("s_E_rs", 32'(s_E_rs_data), 32'(exp_e(ers)));
      check("s_E_rt", 32'(s_E_rt_data), 32'(exp_e(ert)));
    end
  end

  task automatic set_d(input logic [4:0] dst, input logic [1:0] tnew,
                       input logic [4:0] rs, input logic rsu, input logic [1:0] rstu,
                       input logic [4:0] rt, input logic rtu, input logic [1:0] rttu,
                       input logic fl);
    D_dst = dst; D_tnew = tnew; D_rs = rs; D_rs_used = rsu; D_rs_tuse = rstu;
    D_rt = rt; D_rt_used = rtu; D_rt_tuse = rttu; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_sDrs", 32'(s_D_rs_data), 0);
    check("rst_sDrt", 32'(s_D_rt_data), 0);
    check("rst_sErs", 32'(s_E_rs_data), 0);
    check("rst_sErt", 32'(s_E_rt_data), 0);

    // addu $8 then consumer with tuse=1
    set_d(8, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 8, 1, 1, 0, 0, 0, 0); #1;
    check("alu_stall", 32'(stall), 0);
    check("alu_sDrs", 32'(s_D_rs_data), 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("alu_sErs", 32'(s_E_rs_data), 3'b010);

    // lw $9 then beq on $9: two stall cycles
    set_d(9, 2, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 9, 1, 0, 0, 0, 0, 0); #1;
    check("lw_stall1", 32'(stall), 1);
    tick(); #1;
    check("lw_stall2", 32'(stall), 1);
    tick(); #1;
    check("lw_release", 32'(stall), 0);
    tick();

    // lui $10 then immediate use from E
    set_d(10, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 10, 1, 0, 0); #1;
    check("lui_sDrt", 32'(s_D_rt_data), 3'b001);
    check("lui_stall", 32'(stall), 0);
    tick();

    // $11 in W (ready) and E (not ready): E wins
    set_d(11, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(11, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 11, 1, 0, 0, 0, 0, 0); #1;
    check("nearest_stall", 32'(stall), 1);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // $0 never tracked; flushed producer leaves no trace
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_d(0, 0, 0, 1, 0, 0, 1, 0, 0); #1;
    check("zero_stall", 32'(stall), 0);
    check("zero_sDrs", 32'(s_D_rs_data), 0);
    tick();
    set_d(12, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    set_d(0, 0, 12, 1, 0, 0, 0, 0, 0); #1;
    check("flush_sDrs", 32'(s_D_rs_data), 0);
    check("flush_stall", 32'(stall), 0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_d(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            ($urandom_range(0, 9) == 0));
      tick();
    end
    rst = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #6;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
